// File: rtl/sync_debounce_pkg.sv
// sync_debounce_pkg: shared FSM state type and parameter legality helper
package sync_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } dbnc_state_t;

  function automatic bit params_ok(input int sync_stages, input int debounce_cycles);
    return sync_stages >= 2 && debounce_cycles >= 1;
  endfunction

endpackage

// File: rtl/sync_debounce_sync_chain.sv
// sync_chain: plain flop chain bringing an asynchronous level into clk
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r;

  // shift the raw level through the chain, clearing it on reset
  always_ff @(posedge clk)
    r <= !rstn ? '0 : {r[STAGES-2:0], d};

  assign q = r[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: synchronize, debounce and edge-detect an asynchronous level
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic din_async,
  output logic dout,
  output logic dout_bar,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam bit PARAMS_OK = params_ok(SYNC_STAGES, DEBOUNCE_CYCLES);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("sync_debounce: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
    end
  endgenerate

  dbnc_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic s, mis, in_chk, commit;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (din_async),
    .q    (s)
  );

  // qualify a synced mismatch: commit after DEBOUNCE_CYCLES consecutive mismatching edges
  always_comb begin
    mis     = s != dout;
    in_chk  = state inside {CHECK_HI, CHECK_LO};
    commit  = mis && (in_chk ? cnt == LAST : DEBOUNCE_CYCLES == 1);
    state_n = commit ? (s ? STABLE_HI : STABLE_LO)
            : mis    ? (s ? CHECK_HI : CHECK_LO)
            :          (dout ? STABLE_HI : STABLE_LO);
    cnt_n   = (commit || !mis) ? '0 : in_chk ? cnt + 1'b1 : CW'(1);
  end

  // state, counter and registered outputs; pulses last only the commit cycle
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= STABLE_LO;
      cnt      <= '0;
      dout     <= 1'b0;
      dout_bar <= 1'b1;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dout     <= commit ? s : dout;
      dout_bar <= commit ? ~s : dout_bar;
      rise     <= commit && s;
      fall     <= commit && !s;
      busy     <= state_n inside {CHECK_HI, CHECK_LO};
    end
  end

  // self-check of output and counter invariants outside reset
  always @(posedge clk) begin
    if (rstn) begin
      a_comp: assert (dout == ~dout_bar) else $error("%0t: dout/dout_bar not complementary", $time);
      a_excl: assert (!(rise && fall)) else $error("%0t: rise and fall together", $time);
      a_rise: assert (!rise || dout) else $error("%0t: rise without dout high", $time);
      a_fall: assert (!fall || !dout) else $error("%0t: fall without dout low", $time);
      a_cnt:  assert (32'(cnt) < DEBOUNCE_CYCLES) else $error("%0t: cnt out of range", $time);
    end
  end

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: table-driven and scoreboard checks of sync_debounce
module tb_sync_debounce;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din = 1'b0;
  logic din1 = 1'b0;
  logic dout, dout_bar, rise, fall, busy;
  logic dout1, dout_bar1, rise1, fall1, busy1;
  int n_chk = 0;
  int n_fail = 0;
  int busy1_seen = 0;

  typedef struct {
    logic       rstn;
    logic       din;
    logic [3:0] exp;
  } vec_t;

  vec_t tbl[$];
  logic [4:0] exp_q[$];
  logic lvl_q[$];

  always #5 clk = ~clk;

  sync_debounce dut (
    .clk       (clk),
    .rstn      (rstn),
    .din_async (din),
    .dout      (dout),
    .dout_bar  (dout_bar),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy)
  );

  sync_debounce #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .din_async (din1),
    .dout      (dout1),
    .dout_bar  (dout_bar1),
    .rise      (rise1),
    .fall      (fall1),
    .busy      (busy1)
  );

  always @(negedge clk)
    if (rstn && busy1) busy1_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] full(input logic [3:0] e);
    return {e[3], ~e[3], e[2:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string name, input logic r, input logic d, input logic [3:0] e);
    rstn = r;
    din = d;
    exp_q.push_back(full(e));
    tick();
    chk(name, 32'({dout, dout_bar, rise, fall, busy}), 32'(exp_q.pop_front()));
  endtask

  task automatic add(input logic r, input logic d, input logic [3:0] e, input int n);
    for (int i = 0; i < n; i++) tbl.push_back('{r, d, e});
  endtask

  initial begin
    logic e, prev;
    int n_rise, n_fall;
    // exp = {dout, rise, fall, busy}
    add(1'b0, 1'b1, 4'b0000, 3);
    add(1'b1, 1'b0, 4'b0000, 2);
    add(1'b1, 1'b1, 4'b0000, 2);
    add(1'b1, 1'b1, 4'b0001, 3);
    add(1'b1, 1'b1, 4'b1100, 1);
    add(1'b1, 1'b1, 4'b1000, 2);
    add(1'b1, 1'b0, 4'b1000, 2);
    add(1'b1, 1'b0, 4'b1001, 3);
    add(1'b1, 1'b0, 4'b0010, 1);
    add(1'b1, 1'b0, 4'b0000, 1);
    add(1'b1, 1'b1, 4'b0000, 2);
    add(1'b1, 1'b1, 4'b0001, 1);
    add(1'b1, 1'b0, 4'b0001, 2);
    add(1'b1, 1'b0, 4'b0000, 2);
    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].rstn, tbl[i].din, tbl[i].exp);

    step("mid_sync1", 1'b1, 1'b1, 4'b0000);
    step("mid_sync2", 1'b1, 1'b1, 4'b0000);
    step("mid_cnt1", 1'b1, 1'b1, 4'b0001);
    step("mid_cnt2", 1'b1, 1'b1, 4'b0001);
    step("mid_reset", 1'b0, 1'b1, 4'b0000);
    chk("mid_cnt_zero", 32'(dut.cnt), 32'd0);
    for (int i = 0; i < 5; i++) step("mid_requal", 1'b1, 1'b1, i < 2 ? 4'b0000 : 4'b0001);
    step("mid_rise", 1'b1, 1'b1, 4'b1100);
    din = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_back_low", 32'({dout, rise, fall, busy}), 32'd0);

    din1 = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("d1_high", 32'({dout1, dout_bar1, rise1, fall1}), 32'b1000);
    din1 = 1'b0;
    tick();
    chk("d1_fall_e1", 32'({dout1, dout_bar1, rise1, fall1}), 32'b1000);
    tick();
    chk("d1_fall_e2", 32'({dout1, dout_bar1, rise1, fall1}), 32'b1000);
    tick();
    chk("d1_fall_e3", 32'({dout1, dout_bar1, rise1, fall1}), 32'b0101);
    tick();
    chk("d1_fall_e4", 32'({dout1, dout_bar1, rise1, fall1}), 32'b0100);

    for (int i = 0; i < 5; i++) lvl_q.push_back(1'b0);
    prev = 1'b0;
    n_rise = 0;
    n_fall = 0;
    for (int i = 0; i < 46; i++) begin
      din = i < 40 ? ((i / 5) % 2 == 0) : 1'b0;
      lvl_q.push_back(din);
      tick();
      e = lvl_q.pop_front();
      chk($sformatf("tog%0d", i), 32'({dout, dout_bar, rise, fall}), 32'({e, ~e, e & ~prev, ~e & prev}));
      n_rise += int'(rise);
      n_fall += int'(fall);
      prev = e;
    end
    chk("tog_rises", 32'(n_rise), 32'd4);
    chk("tog_falls", 32'(n_fall), 32'd4);
    chk("d1_busy_never", 32'(busy1_seen), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
# sync_debounce

Input-conditioning stage that drives the `d` input of the team's `dff` register stage. It synchronizes an asynchronous level input into `clk` and rejects glitches shorter than a programmable number of cycles. It presents the result as a registered complementary pair with one-cycle edge pulses. Immediate assertions embedded in the block check its own invariants every cycle.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 4: consecutive mismatching synced samples required to commit a new level; legal range ≥ 1.
- `clk`, input, 1: clock; all state updates on its rising edge.
- `rstn`, input, 1: reset, synchronous, active-low.
- `din_async`, input, 1: raw asynchronous level.
- `dout`, output, 1: debounced level (registered).
- `dout_bar`, output, 1: always `~dout` (registered, not derived combinationally).
- `rise`, output, 1: one-cycle pulse, coincident with `dout` going 0→1.
- `fall`, output, 1: one-cycle pulse, coincident with `dout` going 1→0.
- `busy`, output, 1: high while a candidate transition is being qualified.

## Operation
- `s` is the output of the last synchronizer flop.
- FSM states: `STABLE_LO`, `CHECK_HI`, `STABLE_HI`, `CHECK_LO`.
- Counter `cnt` has width `$clog2(DEBOUNCE_CYCLES+1)` and never exceeds `DEBOUNCE_CYCLES-1`.
- Define mismatch as `s != dout`.
- In `STABLE_*`, on a mismatch edge:
  - If `DEBOUNCE_CYCLES==1`: commit immediately.
  - Otherwise: go to the matching `CHECK_*` with `cnt=1`.
- In `CHECK_*`, on each edge:
  - Match: return to the current `STABLE_*` and set `cnt=0` (glitch rejected; outputs unchanged).
  - Mismatch with `cnt==DEBOUNCE_CYCLES-1`: commit.
  - Otherwise: `cnt++`.
- Commit, all on the same edge:
  - `dout<=s`, `dout_bar<=~s`.
  - `rise` or `fall` asserts for exactly that cycle.
  - State goes to `STABLE_HI`/`STABLE_LO` and `cnt=0`.
- `busy` = state is `CHECK_*`. It is registered with the state.
- Immediate assertions run in `always @(posedge clk)` and are skipped while `!rstn`. Each failure reports `$error` with `$time`.
  - `dout == ~dout_bar`
  - `!(rise && fall)`
  - `rise -> dout`, `fall -> !dout`
  - `cnt < DEBOUNCE_CYCLES`

## Timing
- Reset (`rstn==0` at an edge), values after that edge:
  - All synchronizer flops 0.
  - `dout=0`, `dout_bar=1`, `rise=0`, `fall=0`, `busy=0`.
  - State `STABLE_LO`, `cnt=0`.
- Latency: a `din_async` change meeting setup before edge 1 updates `dout` at edge `SYNC_STAGES+DEBOUNCE_CYCLES`. With defaults, that is edge 6.
  - Edges 1–2: synchronizer.
  - Edges 3–5: `cnt` = 1, 2, 3.
  - Edge 6: commit.
- Glitch rejection: a synced mismatch lasting fewer than `DEBOUNCE_CYCLES` consecutive cycles never changes `dout` and produces no pulse.
- Back-to-back transitions: after a commit, a new mismatch may start qualifying on the very next edge. The minimum spacing between commits is `DEBOUNCE_CYCLES` cycles.
- Reset mid-qualification discards the candidate. Outputs return to their reset values on that edge.
- `rise`/`fall` never last more than one cycle, even if `din_async` stays stable.

## Structure
- Package `sync_debounce_pkg` holds:
  - `typedef enum logic [1:0] dbnc_state_t` with the four states.
  - Parameter legality checks as a `localparam`-based elaboration assertion.
- Sub-module `sync_chain #(STAGES)`:
  - Ports: `clk`, `rstn`, `d`, `q`.
  - Synchronous active-low reset to 0; no logic other than the flop chain.
- Top-level: `sync_chain` instance, FSM, counter, output registers, and the assertion block.
- Estimated size: ~150–200 lines.

## Test plan
- Reset: hold `rstn=0` for 3 edges with `din_async=1`. Required: `dout=0`, `dout_bar=1`, `rise=fall=busy=0` throughout.
- Clean rise, defaults: raise `din_async` before edge 1 and hold. Required:
  - `busy=1` after edges 3–5.
  - `dout=1`, `rise=1` after edge 6.
  - `rise=0` after edge 7.
  - No assertion failures.
- Glitch: `din_async` high for 3 cycles, then low. Required: `dout` stays 0, `rise` never asserts, `busy` returns to 0.
- Fall with `DEBOUNCE_CYCLES=1`: from `dout=1`, drop `din_async`. Required: `dout=0`, `fall=1` exactly `SYNC_STAGES+1` edges later, `busy` never asserts.
- Reset mid-check: start a rise and assert `rstn=0` at the edge where `cnt==2`. Required: `dout=0`, `busy=0`, `cnt=0` after that edge, and no `rise` pulse afterward unless the input is requalified from scratch.
- Toggling input: alternate `din_async` every 5 cycles for 40 cycles. Required:
  - Each level change produces exactly one `rise` or `fall`.
  - `dout` lags the input by 6 cycles.
  - No assertion failures.
